// File: rtl/sha_pkg.sv
// ----------------------------------------------------------------------------
// sha_pkg
// Shared definitions for the SHA digest output stage:
//   - SHA variant encodings carried on sha_type
//   - digest word count per variant (32-bit words)
//   - output-stage state enum
//   - digest_word(): picks 32-bit word k of a digest held as eight 64-bit words
// ----------------------------------------------------------------------------
package sha_pkg;

    localparam logic [1:0] SHA224 = 2'b00;
    localparam logic [1:0] SHA256 = 2'b01;
    localparam logic [1:0] SHA384 = 2'b10;
    localparam logic [1:0] SHA512 = 2'b11;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Number of 32-bit digest words emitted for each variant.
    function automatic logic [4:0] digest_words(input logic [1:0] t);
        logic [4:0] n;
        case (t)
            SHA224:  n = 5'd7;
            SHA256:  n = 5'd8;
            SHA384:  n = 5'd12;
            SHA512:  n = 5'd16;
            default: n = 5'd16;
        endcase
        return n;
    endfunction

    // 32-bit types keep their word in the top half of each H entry.
    // 64-bit types emit each H entry as two words, upper half first.
    function automatic logic [31:0] digest_word(input logic [0:7][63:0] h,
                                                input logic             is_64,
                                                input logic [3:0]       k);
        logic [63:0] hw;
        logic [31:0] word;
        if (is_64) begin
            hw   = h[k[3:1]];
            word = k[0] ? hw[31:0] : hw[63:32];
        end else begin
            hw   = h[k[2:0]];
            word = hw[63:32];
        end
        return word;
    endfunction

endpackage

// File: rtl/sha_digest_out.sv
// ----------------------------------------------------------------------------
// sha_digest_out
// Snapshots the final hash words on digest_start, frees the accumulator at
// once, and drains the (variant-truncated) digest onto a valid/ready stream,
// most significant word first.
//
// Parameters:
//   OUT_W        beat width, 32 or 64
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   sha_type     SHA variant, latched at digest_start
//   digest_start single-cycle pulse, H holds the final digest
//   H            eight 64-bit hash words
//   busy         snapshot held / stream in progress
//   dout_data    digest beat
//   dout_valid   beat valid
//   dout_last    final beat of the digest
//   dout_ready   consumer accepts the beat
//   done         one-cycle pulse after the last beat is accepted
// ----------------------------------------------------------------------------
module sha_digest_out
    import sha_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sha_type,
    input  logic             digest_start,
    input  logic [0:7][63:0] H,
    output logic             busy,
    output logic [OUT_W-1:0] dout_data,
    output logic             dout_valid,
    output logic             dout_last,
    input  logic             dout_ready,
    output logic             done
);

    state_t             r_state;
    logic [0:7][63:0]   r_snap;
    logic [1:0]         r_type;
    logic [3:0]         r_cnt;
    logic [OUT_W-1:0]   r_data;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [0:7][63:0]   w_snap_nxt;
    logic [1:0]         w_type_nxt;
    logic [3:0]         w_cnt_nxt;
    logic [OUT_W-1:0]   w_data_nxt;
    logic               w_valid_nxt;
    logic               w_last_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [OUT_W-1:0]   w_beat_start;   // beat 0, taken straight from H at start
    logic [OUT_W-1:0]   w_beat_next;    // beat r_cnt+1 from the snapshot
    logic [3:0]         w_idx_next;
    logic               w_last_next;

    function automatic logic [4:0] beat_count(input logic [1:0] t);
        if (OUT_W == 64) return (digest_words(t) + 5'd1) >> 1;
        else             return digest_words(t);
    endfunction

    assign w_idx_next  = r_cnt + 4'd1;
    assign w_last_next = ({1'b0, w_idx_next} == (beat_count(r_type) - 5'd1));

    generate
        if (OUT_W == 32) begin : g_w32
            assign w_beat_start = digest_word(H, sha_type[1], 4'd0);
            assign w_beat_next  = digest_word(r_snap, r_type[1], w_idx_next);
        end else if (OUT_W == 64) begin : g_w64
            logic [3:0] w_even;
            logic [3:0] w_odd;
            assign w_even = w_idx_next << 1;
            assign w_odd  = w_even | 4'd1;
            assign w_beat_start = {digest_word(H, sha_type[1], 4'd0),
                                   digest_word(H, sha_type[1], 4'd1)};
            // SHA224 has an odd word count: its final beat is zero-padded.
            assign w_beat_next  = {digest_word(r_snap, r_type[1], w_even),
                                   ({1'b0, w_odd} < digest_words(r_type))
                                       ? digest_word(r_snap, r_type[1], w_odd)
                                       : 32'h0};
        end else begin : g_bad_out_w
            $error("sha_digest_out: OUT_W must be 32 or 64");
        end
    endgenerate

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned and infers a latch.
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_type_nxt  = r_type;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = 4'd0;
                if (digest_start) begin
                    w_snap_nxt  = H;
                    w_type_nxt  = sha_type;
                    w_state_nxt = SEND;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_data_nxt  = w_beat_start;
                    w_last_nxt  = 1'b0;     // every variant has at least 4 beats
                end
            end
            SEND: begin
                // digest_start is ignored here: snapshot and counter stay put.
                if (r_valid && dout_ready) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_data_nxt  = '0;
                        w_cnt_nxt   = 4'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt  = w_idx_next;
                        w_data_nxt = w_beat_next;
                        w_last_nxt = w_last_next;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            // NOTE: the snapshot is plain flops, not a RAM, so it is cleared with the rest of the state.
            r_snap  <= '0;
            r_type  <= 2'b00;
            r_cnt   <= 4'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            r_state <= w_state_nxt;
            r_snap  <= w_snap_nxt;
            r_type  <= w_type_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy       = r_busy;
    assign dout_data  = r_data;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign done       = r_done;

endmodule
